// File: rtl/serdes_frame_core.sv
// -----------------------------------------------------------------------------
// serdes_frame_core
//
// Framed serialiser / deserialiser. The TX side takes a WIDTH-bit word on a
// valid/ready handshake and sends start(0), WIDTH data bits, an optional
// parity bit and stop(1) on a registered serial line that idles high. The RX
// side hunts for a start bit, samples one bit per clock and delivers the word
// together with parity and framing error flags. With loopback set, RX listens
// to this core's own ser_out instead of ser_in.
//
// Parameters
//   WIDTH      data bits per frame (4..16)
//   PARITY     0 = none, 1 = even, 2 = odd
//   MSB_FIRST  0 = data LSB first, 1 = MSB first (both directions)
//
// Ports
//   clk       clock
//   rst_n     asynchronous active-low reset
//   tx_data   word to transmit, captured on handshake
//   tx_valid  tx_data valid
//   tx_ready  TX can accept a word (IDLE or STOP state)
//   ser_out   serial line out, registered, idle high
//   ser_in    serial line in, asynchronous to clk
//   loopback  1 = RX takes ser_out internally, ser_in ignored
//   rx_data   last received word, held until the next frame completes
//   rx_valid  one-cycle pulse, frame complete
//   rx_perr   parity mismatch, qualified by rx_valid
//   rx_ferr   stop bit sampled 0, qualified by rx_valid
// -----------------------------------------------------------------------------
module serdes_frame_core #(
    parameter int WIDTH     = 8,
    parameter int PARITY    = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             ser_out,
    input  logic             ser_in,
    input  logic             loopback,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_perr,
    output logic             rx_ferr
);

    localparam bit HAS_PAR = (PARITY != 0);
    localparam bit ODD_PAR = (PARITY == 2);
    localparam bit MSB_1ST = (MSB_FIRST != 0);
    localparam int CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_t;

    // -------------------------------------------------------------------------
    // TX
    // -------------------------------------------------------------------------
    tx_state_t        r_tx_state;
    logic [WIDTH-1:0] r_tx_sh;
    logic             r_tx_par;
    logic [CW-1:0]    r_tx_cnt;
    logic             r_ser_out;

    logic             w_tx_hs;
    logic             w_tx_bit;
    logic [WIDTH-1:0] w_tx_sh_shift;

    // A new word can be taken while the stop bit is on the line, which is
    // what gives back-to-back frames without an idle gap.
    assign tx_ready = (r_tx_state == TX_IDLE) || (r_tx_state == TX_STOP);
    assign w_tx_hs  = tx_valid && tx_ready;
    assign ser_out  = r_ser_out;

    // The next data bit always comes from the same end of the shift register;
    // the register moves towards that end after each bit.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path; the defaults here keep synthesis from inferring latches.
        w_tx_bit      = r_tx_sh[0];
        w_tx_sh_shift = {1'b0, r_tx_sh[WIDTH-1:1]};
        if (MSB_1ST) begin
            w_tx_bit      = r_tx_sh[WIDTH-1];
            w_tx_sh_shift = {r_tx_sh[WIDTH-2:0], 1'b0};
        end
    end

    // NOTE: state registers use non-blocking assignments so that every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_sh    <= '0;
            r_tx_par   <= 1'b0;
            r_tx_cnt   <= '0;
            r_ser_out  <= 1'b1;
        end else if (w_tx_hs) begin
            // Only reachable from IDLE or STOP. Parity is computed from the
            // captured word, so later tx_data changes cannot affect the frame.
            r_tx_sh    <= tx_data;
            r_tx_par   <= (^tx_data) ^ ODD_PAR;
            r_ser_out  <= 1'b0;
            r_tx_state <= TX_START;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_ser_out <= 1'b1;
                end
                TX_START: begin
                    r_ser_out  <= w_tx_bit;
                    r_tx_sh    <= w_tx_sh_shift;
                    r_tx_cnt   <= '0;
                    r_tx_state <= TX_DATA;
                end
                TX_DATA: begin
                    // r_tx_cnt indexes the bit currently on the line.
                    if (r_tx_cnt == LAST_BIT) begin
                        r_ser_out  <= HAS_PAR ? r_tx_par : 1'b1;
                        r_tx_state <= HAS_PAR ? TX_PAR : TX_STOP;
                    end else begin
                        r_ser_out <= w_tx_bit;
                        r_tx_sh   <= w_tx_sh_shift;
                        r_tx_cnt  <= r_tx_cnt + 1'b1;
                    end
                end
                TX_PAR: begin
                    r_ser_out  <= 1'b1;
                    r_tx_state <= TX_STOP;
                end
                TX_STOP: begin
                    r_ser_out  <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
                default: begin
                    r_ser_out  <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // RX
    // -------------------------------------------------------------------------
    logic [1:0]       r_sync;
    rx_state_t        r_rx_state;
    logic [WIDTH-1:0] r_rx_sh;
    logic [CW-1:0]    r_rx_cnt;
    logic             r_rx_par;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_perr;
    logic             r_rx_ferr;

    logic             w_rx_bit;
    logic [WIDTH-1:0] w_rx_sh_next;

    // Two-flop synchroniser for the asynchronous line; it resets to the idle
    // level so RX does not see a phantom start bit after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], ser_in};
        end
    end

    // ser_out is already in this clock domain, so loopback skips the
    // synchroniser.
    assign w_rx_bit = loopback ? r_ser_out : r_sync[1];

    // Incoming bits enter at the far end so the first bit ends up in the
    // position it was sent from.
    always_comb begin
        w_rx_sh_next = {w_rx_bit, r_rx_sh[WIDTH-1:1]};
        if (MSB_1ST) begin
            w_rx_sh_next = {r_rx_sh[WIDTH-2:0], w_rx_bit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_sh    <= '0;
            r_rx_cnt   <= '0;
            r_rx_par   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    // The start bit is consumed in the cycle it is seen.
                    if (!w_rx_bit) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    r_rx_sh <= w_rx_sh_next;
                    if (r_rx_cnt == LAST_BIT) begin
                        r_rx_state <= HAS_PAR ? RX_PAR : RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_PAR: begin
                    r_rx_par   <= w_rx_bit;
                    r_rx_state <= RX_STOP;
                end
                RX_STOP: begin
                    // Errors are reported, never waited on: the frame is
                    // delivered and the FSM returns to hunting regardless.
                    r_rx_data  <= r_rx_sh;
                    r_rx_perr  <= HAS_PAR && ((^r_rx_sh) ^ r_rx_par ^ ODD_PAR);
                    r_rx_ferr  <= ~w_rx_bit;
                    r_rx_valid <= 1'b1;
                    r_rx_state <= RX_IDLE;
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_perr  = r_rx_perr;
    assign rx_ferr  = r_rx_ferr;

endmodule

// File: doc/serdes_frame_core.md
# serdes_frame_core

Parametrised framed serialiser/deserialiser, the successor to the fixed 8-bit SerDes core behind the Tiny Tapeout wrapper. The TX side accepts a WIDTH-bit word on a valid/ready handshake and shifts out a framed bit stream: start bit, data, optional parity, stop bit. The RX side hunts for a start bit, deserialises a frame and reports the word with parity and framing error flags. An internal loopback mode connects TX to RX for self-test.

## Interface
- WIDTH, 8: data bits per frame, 4..16.
- PARITY, 1: 0 = no parity bit, 1 = even, 2 = odd.
- MSB_FIRST, 0: 0 = data LSB first, 1 = MSB first; applies to both TX and RX.

Clock and reset are fixed: one clock; reset is asynchronous and active-low.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  WIDTH  word to transmit, captured on handshake
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX can accept a word
- ser_out  out  1  serial line out, registered, idle high
- ser_in  in  1  serial line in, asynchronous
- loopback  in  1  1 = RX takes ser_out internally, ser_in ignored
- rx_data  out  WIDTH  last received word, held until next frame completes
- rx_valid  out  1  one-cycle pulse, frame complete
- rx_perr  out  1  parity mismatch, qualified by rx_valid (0 when PARITY=0)
- rx_ferr  out  1  stop bit sampled 0, qualified by rx_valid

## Operation
- Frame: start(0), WIDTH data bits, parity bit if PARITY!=0, stop(1). Let P = (PARITY!=0). Frame length F = WIDTH+2+P.
- Parity bit: even = XOR of data bits; odd = its inverse.
- TX FSM: IDLE, START, DATA, PAR, STOP.
  - tx_ready = 1 in IDLE and STOP, else 0 (decoded from state).
  - A handshake (tx_valid & tx_ready) loads the shift register and moves to START.
  - START -> DATA. DATA lasts WIDTH cycles, tracked by a bit counter of width clog2(WIDTH). DATA -> PAR if P, else STOP. PAR -> STOP.
  - STOP -> START on a handshake, giving back-to-back frames with no idle gap; otherwise STOP -> IDLE.
  - ser_out = 1 in IDLE.
  - tx_data changes after the handshake have no effect.
- RX input: ser_in passes through a 2-flop synchronizer (reset to 1). rx_bit = loopback ? ser_out : synchronized ser_in. The loopback path bypasses the synchronizer.
- RX FSM: IDLE, DATA, PAR, STOP; one bit sampled per clk, no oversampling.
  - IDLE -> DATA when rx_bit = 0 (start bit consumed).
  - DATA samples WIDTH bits in MSB_FIRST order -> PAR if P, else STOP. PAR -> STOP.
  - STOP always -> IDLE. On the STOP sample edge:
    - rx_data <= assembled word
    - rx_perr <= parity mismatch
    - rx_ferr <= (rx_bit == 0)
    - rx_valid <= 1 for exactly one cycle.
- Errors never stall the RX FSM. A frame with errors is still delivered with its flags set.
- Toggling loopback mid-frame may corrupt the in-flight RX frame. It must not lock up either FSM.

## Timing
- Reset values: ser_out=1, tx_ready=1, rx_data=0, rx_valid=0, rx_perr=0, rx_ferr=0, both FSMs in IDLE, synchronizer=1.
- Asserting rst_n low mid-frame aborts both FSMs immediately. No partial rx_valid is produced.
- Handshake in cycle t:
  - ser_out = start in cycle t+1.
  - Data bits in cycles t+2 .. t+1+WIDTH.
  - Parity in cycle t+2+WIDTH (if P).
  - Stop in cycle t+2+WIDTH+P.
- Loopback latency: rx_valid is high in cycle t+3+WIDTH+P, i.e. t+12 for WIDTH=8, PARITY=1.
- External path (ser_in): add 2 cycles of synchronizer latency.
- Sustained throughput: one word per F cycles when tx_valid is held high.

## Test plan
- Reset: hold rst_n=0 -> all outputs at their reset values; release -> ser_out stays 1, tx_ready=1, no rx_valid for 50 idle cycles.
- Loopback, WIDTH=8, PARITY=1, tx_data=0xA5 accepted at t -> ser_out = 0,1,0,1,0,0,1,0,1,0,1 over t+1..t+11; rx_valid at t+12 with rx_data=0xA5, perr=0, ferr=0.
- Back-to-back loopback: 0x00 then 0xFF with tx_valid held high -> the second handshake occurs in the STOP cycle with no idle gap; rx_valid at t+12 and t+23 carrying 0x00 and 0xFF, no error flags.
- External ser_in, bench drives a frame for 0x3C with a wrong parity bit -> rx_valid with rx_data=0x3C, rx_perr=1, rx_ferr=0; a second frame with stop=0 -> rx_ferr=1; a following clean frame is received correctly.
- rst_n pulsed low in the middle of a TX DATA phase -> ser_out=1 and tx_ready=1 immediately; no rx_valid is produced; the next frame after reset completes normally.
- Config WIDTH=12, PARITY=0, MSB_FIRST=1, loopback, tx_data=0x8F1 -> ser_out = 0, 1000 1111 0001, 1; rx_valid at t+15 with rx_data=0x8F1, rx_perr=0.
